// File: rtl/fd_pkg.sv
// Shared types and constants for the finger-drill round sequencer and its LFSR.
package fd_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        PLAY = 3'd2,
        HIT  = 3'd3,
        MISS = 3'd4,
        OVER = 3'd5
    } state_t;

    localparam int KEY_W   = 4;
    localparam int TIME_W  = 4;
    localparam int SCORE_W = 8;

    // Fibonacci taps 8,6,5,4 expressed as a mask over lfsr[7:0].
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic lfsr_fb(input logic [7:0] value);
        return ^(value & LFSR_TAPS);
    endfunction

    function automatic logic [KEY_W-1:0] onehot4(input logic [1:0] sel);
        logic [KEY_W-1:0] result;
        case (sel)
            2'd0:    result = 4'b0001;
            2'd1:    result = 4'b0010;
            2'd2:    result = 4'b0100;
            2'd3:    result = 4'b1000;
            default: result = 4'b0000;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/target_lfsr.sv
// Free-running 8-bit Fibonacci LFSR used to pick the next target finger.
module target_lfsr
    import fd_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] lfsr
);

    // Shift every cycle, regardless of game state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {lfsr[6:0], lfsr_fb(lfsr)};
        end
    end

endmodule

// File: rtl/round_sequencer.sv
// Round controller: arms the timer, presents a target, judges key presses,
// and keeps score, lives and the shrinking round time.
module round_sequencer
    import fd_pkg::*;
#(
    parameter logic [3:0] INIT_TIME = 4'd5,
    parameter logic [3:0] MIN_TIME  = 4'd2,
    parameter int         SPEEDUP   = 4,
    parameter logic [1:0] LIVES     = 2'd3,
    parameter logic [7:0] SEED      = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] key,
    input  logic       tmr_cout,
    input  logic [3:0] tmr_sum,
    output logic       tmr_run,
    output logic       tmr_clr,
    output logic [3:0] round_time,
    output logic [3:0] target,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic       hit_pulse,
    output logic       miss_pulse,
    output logic       game_over
);

    state_t      state_r;
    logic [7:0]  score_r;
    logic [1:0]  lives_r;
    logic [3:0]  round_time_r;
    logic [3:0]  target_r;
    logic [7:0]  hit_cnt_r;
    logic        armed_r;
    logic [7:0]  lfsr_s;
    logic [3:0]  cand_target_s;
    logic [3:0]  next_target_s;
    logic        key_hit_s;
    logic        key_wrong_s;
    logic        unused_bits_s;

    target_lfsr #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .lfsr  (lfsr_s)
    );

    // Elapsed ticks and the upper LFSR bits play no part in the decisions.
    assign unused_bits_s = ^{tmr_sum, lfsr_s[7:2]};

    // Next target and key classification.
    always_comb begin
        cand_target_s = onehot4(lfsr_s[1:0]);
        if (cand_target_s == target_r) begin
            next_target_s = {cand_target_s[2:0], cand_target_s[3]};
        end else begin
            next_target_s = cand_target_s;
        end
        key_hit_s   = armed_r && (key == target_r);
        key_wrong_s = armed_r && (key != 4'b0000) && (key != target_r);
    end

    // Game state machine with score, lives and round-time bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            score_r      <= 8'd0;
            lives_r      <= LIVES;
            round_time_r <= INIT_TIME;
            target_r     <= 4'd0;
            hit_cnt_r    <= 8'd0;
            armed_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE, OVER: begin
                    if (start) begin
                        state_r      <= ARM;
                        score_r      <= 8'd0;
                        lives_r      <= LIVES;
                        round_time_r <= INIT_TIME;
                        hit_cnt_r    <= 8'd0;
                    end
                end
                ARM: begin
                    target_r <= next_target_s;
                    armed_r  <= 1'b0;
                    state_r  <= PLAY;
                end
                PLAY: begin
                    if (key == 4'b0000) begin
                        armed_r <= 1'b1;
                    end
                    if (key_hit_s) begin
                        state_r <= HIT;
                    end else if (key_wrong_s || tmr_cout) begin
                        state_r <= MISS;
                    end
                end
                HIT: begin
                    if (score_r != 8'hFF) begin
                        score_r <= score_r + 8'd1;
                    end
                    if (hit_cnt_r == 8'(SPEEDUP - 1)) begin
                        hit_cnt_r <= 8'd0;
                        if (round_time_r > MIN_TIME) begin
                            round_time_r <= round_time_r - 4'd1;
                        end
                    end else begin
                        hit_cnt_r <= hit_cnt_r + 8'd1;
                    end
                    state_r <= ARM;
                end
                MISS: begin
                    hit_cnt_r <= 8'd0;
                    if (lives_r != 2'd0) begin
                        lives_r <= lives_r - 2'd1;
                    end
                    if (lives_r <= 2'd1) begin
                        target_r <= 4'd0;
                        state_r  <= OVER;
                    end else begin
                        state_r  <= ARM;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    target_r <= 4'd0;
                    armed_r  <= 1'b0;
                end
            endcase
        end
    end

    assign tmr_run    = (state_r == PLAY);
    assign tmr_clr    = (state_r == ARM);
    assign hit_pulse  = (state_r == HIT);
    assign miss_pulse = (state_r == MISS);
    assign game_over  = (state_r == OVER);
    assign round_time = round_time_r;
    assign target     = target_r;
    assign score      = score_r;
    assign lives      = lives_r;

endmodule

// File: doc/round_sequencer.md
Name: round_sequencer

Overview:
- Game-level controller that sequences the round countdown timer (`timing`).
- Per round it clears and starts the timer, presents a one-hot target finger, and judges the player's key press against that target or against timer expiry.
- Keeps score and lives, and shortens the round time as the player succeeds.
- Sits between the key-input synchroniser/debouncer and the timer, display and score logic.

Parameters:
- INIT_TIME, 5, round time (ticks) loaded at game start; 4-bit.
- MIN_TIME, 2, floor for round time; 1 <= MIN_TIME <= INIT_TIME.
- SPEEDUP, 4, consecutive-hit count that triggers a round_time decrement; >= 1.
- LIVES, 3, lives at game start; 1..3.
- SEED, 8'hA5, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; starts a game from IDLE or OVER.
- key  in  4  debounced, synchronised finger keys; level, active-high.
- tmr_cout  in  1  timer expiry from `timing`.
- tmr_sum  in  4  elapsed ticks from `timing`; pass-through only, not used in decisions.
- tmr_run  out  1  drives the timer's gameState.
- tmr_clr  out  1  one-cycle timer clear pulse.
- round_time  out  4  drives the timer's roundTime.
- target  out  4  one-hot target finger; 0 when no round is active.
- score  out  8  hits, saturating at 255.
- lives  out  2  remaining lives.
- hit_pulse  out  1  one cycle per correct hit.
- miss_pulse  out  1  one cycle per miss.
- game_over  out  1  high while in OVER.

Behaviour:
- Reset (reset=0, asynchronous):
  - state IDLE; score 0; lives LIVES; round_time INIT_TIME; target 0; hit_cnt 0.
  - armed 0; LFSR = SEED.
  - tmr_run, tmr_clr, hit_pulse, miss_pulse, game_over all 0.
  - Asserting reset mid-round aborts the round immediately; no miss is counted.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Advances every clk cycle in every state.
- All outputs are Moore outputs (decoded from state) or registered.
- States:
  - IDLE:
    - All outputs idle. `start` -> ARM, and in the same edge: score 0, lives LIVES, round_time INIT_TIME, hit_cnt 0.
  - ARM (exactly 1 cycle):
    - tmr_clr=1, tmr_run=0.
    - target <= onehot(lfsr[1:0]); if that equals the previous target, rotate it left by 1.
    - armed <= 0. Next state PLAY.
  - PLAY:
    - tmr_run=1.
    - armed sets on the first cycle with key==0. Key presses are ignored while armed=0, so a key held across rounds never counts.
    - Priority 1, correct hit: armed and key==target -> HIT.
    - Priority 2, wrong key: armed and key!=0 and key!=target (including multi-key presses) -> MISS.
    - Priority 3, timeout: tmr_cout=1 -> MISS.
    - tmr_cout in the same cycle as a correct key -> HIT (priority 1 wins).
    - `start` is ignored.
  - HIT (1 cycle):
    - hit_pulse=1; tmr_run=0.
    - score <= score+1, saturating at 255.
    - If hit_cnt==SPEEDUP-1: hit_cnt <= 0 and round_time <= round_time-1 unless already MIN_TIME. Otherwise hit_cnt++.
    - Next state ARM.
  - MISS (1 cycle):
    - miss_pulse=1; tmr_run=0; hit_cnt <= 0.
    - lives <= lives-1.
    - If lives was 1 -> OVER, else -> ARM.
  - OVER:
    - game_over=1; tmr_run=0; target 0.
    - score, lives and round_time hold their values.
    - `start` -> ARM, with the same reinitialisation as in IDLE.
- Latency:
  - Qualifying key sampled at edge n: state is HIT/MISS for cycle n..n+1; score/lives update at edge n+1; ARM (tmr_clr) during cycle n+1..n+2.
  - start at edge n: tmr_run rises after edge n+1.
- Width rules:
  - round_time never goes below MIN_TIME.
  - lives never underflows; 0 only in OVER.

Decomposition:
- Shared package fd_pkg:
  - state enum {IDLE, ARM, PLAY, HIT, MISS, OVER}.
  - KEY_W=4, TIME_W=4, SCORE_W=8.
  - LFSR tap constant.
- One sub-module: target_lfsr (8-bit free-running LFSR, parameter SEED, output lfsr[7:0]).

Test Plan:
- Reset check: drive reset=0 then release -> score=0, lives=3, round_time=5, target=0, tmr_run=0, game_over=0.
- Game start: pulse start -> exactly one cycle of tmr_clr=1 with tmr_run=0, then tmr_run=1; target equals onehot(lfsr[1:0]) computed from SEED=8'hA5 plus elapsed cycles.
- Correct hit: release keys, then drive key=target -> one hit_pulse, score 0->1, new ARM; a key still held into the new round produces no hit/miss until released.
- Miss and game over: assert tmr_cout with key=0 three times -> three miss_pulses, lives 3->2->1->0, game_over=1, tmr_run=0; further key presses do nothing; start -> lives=3, score=0.
- Speed-up: 4 consecutive hits -> round_time 5->4; 12 hits -> 2; 16 hits -> still 2; a miss between hits resets hit_cnt.
- Boundaries:
  - tmr_cout and correct key in the same cycle -> HIT.
  - key=4'b0011 -> MISS.
  - reset asserted mid-PLAY -> immediate IDLE, lives unchanged at reset value 3.
  - score at 255 plus a hit -> stays 255.
